// File: rtl/dcache_pkg.sv
// Shared defaults for the n-way data cache tag/data SRAM and its LRU helper.
// tag_o is packed as {valid, dirty, tag}; the bit offsets below assume the default tag width.
package dcache_pkg;
    localparam int DEF_WAYS   = 4;
    localparam int DEF_SETS   = 16;
    localparam int DEF_TAG_W  = 23;
    localparam int DEF_LINE_W = 256;

    localparam int VALID_BIT = DEF_TAG_W + 1;
    localparam int DIRTY_BIT = DEF_TAG_W;

    typedef enum logic [1:0] {
        ACC_RD_MISS = 2'b00,
        ACC_RD_HIT  = 2'b01,
        ACC_WR_MISS = 2'b10,
        ACC_WR_HIT  = 2'b11
    } acc_kind_e;
endpackage

// File: rtl/dcache_lru_age.sv
// True-LRU age update and victim choice for one set's age vector (age 0 = MRU).
// Purely combinational; the caller owns the per-set age storage.
module dcache_lru_age
    import dcache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int AW   = $clog2(WAYS)
) (
    input  logic [WAYS*AW-1:0] ages_i,
    input  logic [WAYS-1:0]    valid_i,
    input  logic               hit_i,
    input  logic [AW-1:0]      hit_way_i,
    output logic [AW-1:0]      sel_way_o,
    output logic [WAYS*AW-1:0] ages_o
);
    logic [AW-1:0] victim;
    logic          found;
    logic [AW-1:0] old_age;

    // Fill invalid ways lowest-first before evicting anything live.
    always_comb begin
        found  = 1'b0;
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                victim = AW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages_i[w*AW +: AW] == AW'(WAYS - 1)) begin
                    victim = AW'(w);
                end
            end
        end
    end

    assign sel_way_o = hit_i ? hit_way_i : victim;
    assign old_age   = ages_i[int'(sel_way_o)*AW +: AW];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
            logic [AW-1:0] age_cur;
            assign age_cur = ages_i[gi*AW +: AW];
            assign ages_o[gi*AW +: AW] = (sel_way_o == AW'(gi)) ? '0 :
                                         (age_cur < old_age)    ? age_cur + 1'b1 :
                                                                  age_cur;
        end
    endgenerate
endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative cache storage: tag/valid/dirty/age in flops, line data in per-way SRAM.
// One-cycle lookup/allocate with true-LRU replacement; results appear the cycle after the access.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      write_i,
    input  logic [$clog2(SETS)-1:0]   addr_i,
    input  logic [TAG_W-1:0]          tag_i,
    input  logic [LINE_W-1:0]         data_i,
    input  logic                      dirty_i,
    output logic                      valid_o,
    output logic                      hit_o,
    output logic [TAG_W+1:0]          tag_o,
    output logic [LINE_W-1:0]         data_o,
    output logic [$clog2(WAYS)-1:0]   way_o
);
    localparam int AW = $clog2(WAYS);

    function automatic logic [WAYS*AW-1:0] age_init();
        logic [WAYS*AW-1:0] v;
        v = '0;
        for (int w = 0; w < WAYS; w++) begin
            v[w*AW +: AW] = AW'(w);
        end
        return v;
    endfunction

    logic [TAG_W-1:0]   tag_reg   [WAYS][SETS];
    logic [WAYS-1:0]    valid_reg [SETS];
    logic [WAYS-1:0]    dirty_reg [SETS];
    logic [WAYS*AW-1:0] age_reg   [SETS];

    logic                valid_o_reg;
    logic                hit_reg;
    logic [TAG_W+1:0]    tag_o_reg;
    logic [AW-1:0]       way_reg;

    logic [WAYS-1:0]     hit_vec;
    logic                hit_any;
    logic [AW-1:0]       hit_way;
    logic [AW-1:0]       sel_way;
    logic [WAYS*AW-1:0]  age_next;
    logic [TAG_W-1:0]    sel_tag;
    logic                sel_valid;
    logic                sel_dirty;
    acc_kind_e           acc_kind;

    logic [WAYS-1:0][LINE_W-1:0] way_data;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
            assign hit_vec[gi] = valid_reg[addr_i][gi] && (tag_reg[gi][addr_i] == tag_i);
        end
    endgenerate

    assign hit_any = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_way = AW'(w);
            end
        end
    end

    dcache_lru_age #(
        .WAYS (WAYS),
        .AW   (AW)
    ) u_lru (
        .ages_i    (age_reg[addr_i]),
        .valid_i   (valid_reg[addr_i]),
        .hit_i     (hit_any),
        .hit_way_i (hit_way),
        .sel_way_o (sel_way),
        .ages_o    (age_next)
    );

    assign sel_tag   = tag_reg[sel_way][addr_i];
    assign sel_valid = valid_reg[addr_i][sel_way];
    assign sel_dirty = dirty_reg[addr_i][sel_way];
    assign acc_kind  = acc_kind_e'({write_i, hit_any});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                age_reg[s]   <= age_init();
                for (int w = 0; w < WAYS; w++) begin
                    tag_reg[w][s] <= '0;
                end
            end
            valid_o_reg <= 1'b0;
            hit_reg     <= 1'b0;
            tag_o_reg   <= '0;
            way_reg     <= '0;
        end else begin
            valid_o_reg <= enable_i;
            if (enable_i) begin
                hit_reg <= hit_any;
                way_reg <= sel_way;
                case (acc_kind)
                    ACC_RD_HIT: begin
                        age_reg[addr_i] <= age_next;
                        tag_o_reg       <= {1'b1, sel_dirty, sel_tag};
                    end
                    // Read miss reports the would-be victim for writeback but changes nothing.
                    ACC_RD_MISS: begin
                        tag_o_reg <= {sel_valid, sel_dirty, sel_tag};
                    end
                    ACC_WR_HIT: begin
                        dirty_reg[addr_i][sel_way] <= dirty_i;
                        age_reg[addr_i]            <= age_next;
                        tag_o_reg                  <= {1'b1, dirty_i, tag_i};
                    end
                    default: begin
                        valid_reg[addr_i][sel_way] <= 1'b1;
                        dirty_reg[addr_i][sel_way] <= dirty_i;
                        tag_reg[sel_way][addr_i]   <= tag_i;
                        age_reg[addr_i]            <= age_next;
                        tag_o_reg                  <= {sel_valid, sel_dirty, sel_tag};
                    end
                endcase
            end
        end
    end

    // Per-way line SRAM: read-before-write gives the evicted line on a write miss,
    // while a write hit forwards the new line so the output shows post-write contents.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [LINE_W-1:0] mem [SETS];
            logic [LINE_W-1:0] rd_reg;

            always_ff @(posedge clk_i) begin
                if (enable_i && write_i && !rst_i && (sel_way == AW'(gi))) begin
                    mem[addr_i] <= data_i;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rd_reg <= '0;
                end else if (enable_i) begin
                    rd_reg <= (write_i && hit_any && (sel_way == AW'(gi))) ? data_i : mem[addr_i];
                end
            end

            assign way_data[gi] = rd_reg;
        end
    endgenerate

    assign valid_o = valid_o_reg;
    assign hit_o   = hit_reg;
    assign tag_o   = tag_o_reg;
    assign way_o   = way_reg;
    assign data_o  = way_data[way_reg];
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway: a recency-list cache model predicts every output cycle,
// and literal expectations pin the model on the hand-worked eviction scenarios.
module tb_dcache_sram_nway;
    localparam int WAYS   = 4;
    localparam int SETS   = 16;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;
    localparam int AW     = 2;
    localparam int SW     = 4;

    logic              clk_i    = 1'b0;
    logic              rst_i    = 1'b1;
    logic              enable_i = 1'b0;
    logic              write_i  = 1'b0;
    logic [SW-1:0]     addr_i   = '0;
    logic [TAG_W-1:0]  tag_i    = '0;
    logic [LINE_W-1:0] data_i   = '0;
    logic              dirty_i  = 1'b0;
    logic              valid_o;
    logic              hit_o;
    logic [TAG_W+1:0]  tag_o;
    logic [LINE_W-1:0] data_o;
    logic [AW-1:0]     way_o;

    dcache_sram_nway #(
        .WAYS   (WAYS),
        .SETS   (SETS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .tag_i    (tag_i),
        .data_i   (data_i),
        .dirty_i  (dirty_i),
        .valid_o  (valid_o),
        .hit_o    (hit_o),
        .tag_o    (tag_o),
        .data_o   (data_o),
        .way_o    (way_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: per-set recency list of way indices, most recently used first.
    logic              m_valid [WAYS][SETS];
    logic              m_dirty [WAYS][SETS];
    logic [TAG_W-1:0]  m_tag   [WAYS][SETS];
    logic [LINE_W-1:0] m_data  [WAYS][SETS];
    logic              m_known [WAYS][SETS];
    int                m_order [SETS][WAYS];

    logic              e_valid = 1'b0;
    logic              e_hit   = 1'b0;
    logic [TAG_W+1:0]  e_tag   = '0;
    logic [LINE_W-1:0] e_data  = '0;
    logic [AW-1:0]     e_way   = '0;
    logic              e_known = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_tag[w][s]   = '0;
                m_order[s][w] = w;
            end
        end
        e_valid = 1'b0;
        e_hit   = 1'b0;
        e_tag   = '0;
        e_data  = '0;
        e_way   = '0;
        e_known = 1'b1;
    endtask

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (m_order[s][i] == w) p = i;
        end
        for (int i = p; i > 0; i--) begin
            m_order[s][i] = m_order[s][i-1];
        end
        m_order[s][0] = w;
    endtask

    task automatic access(input logic wr, input int s, input logic [TAG_W-1:0] t,
                          input logic [LINE_W-1:0] d, input logic dy);
        int hw;
        int sel;
        logic [TAG_W+1:0]  xt;
        logic [LINE_W-1:0] xd;
        logic              xk;
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = SW'(s);
        tag_i    = t;
        data_i   = d;
        dirty_i  = dy;
        hw = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w][s] && m_tag[w][s] == t) hw = w;
        end
        if (hw >= 0) begin
            sel = hw;
            if (wr) begin
                m_data[sel][s]  = d;
                m_known[sel][s] = 1'b1;
                m_dirty[sel][s] = dy;
            end
            xt = {1'b1, m_dirty[sel][s], t};
            xd = m_data[sel][s];
            xk = m_known[sel][s];
            touch(s, sel);
        end else begin
            sel = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (!m_valid[w][s] && sel < 0) sel = w;
            end
            if (sel < 0) sel = m_order[s][WAYS-1];
            xt = {m_valid[sel][s], m_dirty[sel][s], m_tag[sel][s]};
            xd = m_data[sel][s];
            xk = m_known[sel][s];
            if (wr) begin
                m_valid[sel][s] = 1'b1;
                m_dirty[sel][s] = dy;
                m_tag[sel][s]   = t;
                m_data[sel][s]  = d;
                m_known[sel][s] = 1'b1;
                touch(s, sel);
            end
        end
        @(posedge clk_i);
        #1;
        e_valid = 1'b1;
        e_hit   = (hw >= 0);
        e_way   = AW'(sel);
        e_tag   = xt;
        e_data  = xd;
        e_known = xk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            enable_i = 1'b0;
            @(posedge clk_i);
            #1;
            e_valid = 1'b0;
        end
    endtask

    // Write miss whose clock edge lands while reset is held: nothing may be installed.
    task automatic aborted_write(input int s, input logic [TAG_W-1:0] t);
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = SW'(s);
        tag_i    = t;
        data_i   = rnd_line();
        dirty_i  = 1'b1;
        #2;
        rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        #2;
        rst_i    = 1'b0;
        enable_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        chk("valid_o", LINE_W'(valid_o), LINE_W'(e_valid));
        chk("hit_o",   LINE_W'(hit_o),   LINE_W'(e_hit));
        chk("way_o",   LINE_W'(way_o),   LINE_W'(e_way));
        chk("tag_o",   LINE_W'(tag_o),   LINE_W'(e_tag));
        if (e_known) chk("data_o", data_o, e_data);
    end

    logic [LINE_W-1:0] ln [4];
    logic [LINE_W-1:0] ln_e;
    logic [LINE_W-1:0] ln_e2;

    initial begin
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_known[w][s] = 1'b0;
                m_data[w][s]  = '0;
            end
        end
        model_reset();
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b0;

        // Cold read miss
        access(1'b0, 3, 23'h1, '0, 1'b0);
        chk("cold_valid", LINE_W'(valid_o), LINE_W'(1));
        chk("cold_hit", LINE_W'(hit_o), LINE_W'(0));
        chk("cold_vbit", LINE_W'(tag_o[TAG_W+1]), LINE_W'(0));
        chk("cold_way", LINE_W'(way_o), LINE_W'(0));
        idle(1);

        // Fill set 5, ways in order
        for (int i = 0; i < 4; i++) begin
            ln[i] = rnd_line();
            access(1'b1, 5, 23'hA + 23'(i), ln[i], 1'b1);
            chk("fill_way", LINE_W'(way_o), LINE_W'(i));
        end
        access(1'b0, 5, 23'hC, '0, 1'b0);
        chk("rdC_hit", LINE_W'(hit_o), LINE_W'(1));
        chk("rdC_way", LINE_W'(way_o), LINE_W'(2));
        chk("rdC_data", data_o, ln[2]);

        // Touch 0xA, then 0xE must evict 0xB from way 1
        access(1'b0, 5, 23'hA, '0, 1'b0);
        ln_e = rnd_line();
        access(1'b1, 5, 23'hE, ln_e, 1'b1);
        chk("evict_hit", LINE_W'(hit_o), LINE_W'(0));
        chk("evict_way", LINE_W'(way_o), LINE_W'(1));
        chk("evict_tag", LINE_W'(tag_o), LINE_W'({2'b11, 23'hB}));
        chk("evict_data", data_o, ln[1]);
        access(1'b0, 5, 23'hE, '0, 1'b0);
        chk("rdE_hit", LINE_W'(hit_o), LINE_W'(1));
        chk("rdE_way", LINE_W'(way_o), LINE_W'(1));

        // Write hit clears dirty
        ln_e2 = rnd_line();
        access(1'b1, 5, 23'hE, ln_e2, 1'b0);
        chk("whit_hit", LINE_W'(hit_o), LINE_W'(1));
        chk("whit_dirty", LINE_W'(tag_o[TAG_W]), LINE_W'(0));
        chk("whit_data", data_o, ln_e2);
        idle(2);

        // Back-to-back alternation between the two edge sets
        for (int i = 0; i < 64; i++) begin
            access(1'($urandom_range(0, 1)), (i % 2 == 1) ? 15 : 0,
                   23'($urandom_range(1, 6)), rnd_line(), 1'($urandom_range(0, 1)));
        end
        idle(1);
        access(1'b0, 5, 23'hA, '0, 1'b0);
        access(1'b0, 5, 23'hC, '0, 1'b0);
        access(1'b0, 5, 23'hD, '0, 1'b0);
        access(1'b0, 5, 23'hE, '0, 1'b0);
        chk("set5_E_hit", LINE_W'(hit_o), LINE_W'(1));
        idle(1);

        // Reset during a write miss
        aborted_write(5, 23'h77);
        idle(3);
        access(1'b0, 5, 23'h77, '0, 1'b0);
        chk("abort_77_hit", LINE_W'(hit_o), LINE_W'(0));
        access(1'b0, 5, 23'hA, '0, 1'b0);
        chk("abort_A_hit", LINE_W'(hit_o), LINE_W'(0));
        access(1'b0, 0, 23'h1, '0, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcache_sram_nway.md
DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity; power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 16: sets per way; power of two, >=2.
REQ-003 SHALL have parameter TAG_W, default 23: address tag width.
REQ-004 SHALL have parameter LINE_W, default 256: cache line width in bits.
REQ-005 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable_i  input  1  access request, sampled each rising edge.
REQ-008 SHALL have port write_i  input  1  1 = write/allocate, 0 = read lookup.
REQ-009 SHALL have port addr_i  input  log2(SETS)  set index.
REQ-010 SHALL have port tag_i  input  TAG_W  lookup/install tag.
REQ-011 SHALL have port data_i  input  LINE_W  write/fill line.
REQ-012 SHALL have port dirty_i  input  1  dirty value stored on write.
REQ-013 SHALL have port valid_o  output  1  one-cycle pulse: result of the previous access is on the outputs.
REQ-014 SHALL have port hit_o  output  1  previous access hit.
REQ-015 SHALL have port tag_o  output  TAG_W+2  {valid, dirty, tag} of the selected way.
REQ-016 SHALL have port data_o  output  LINE_W  line of the selected way.
REQ-017 SHALL have port way_o  output  log2(WAYS)  selected way index.

Function
REQ-018 Latency SHALL be one cycle: an access accepted at edge N drives valid_o=1 plus results after edge N; valid_o SHALL be 0 on cycles with no access; hit_o/tag_o/data_o/way_o hold their last values.
REQ-019 Hit SHALL be: some way w in set addr_i has valid=1 and stored tag == tag_i; at most one way can match by construction.
REQ-020 Victim SHALL be the lowest-index invalid way if one exists, else the way with maximum age.
REQ-021 Read hit SHALL output hit_o=1, the hit way's tag/data/index, and make that way MRU.
REQ-022 Read miss SHALL output hit_o=0 and the victim's pre-access tag (with valid, dirty) and data for writeback; no array or age state changes.
REQ-023 Write hit SHALL store data_i into the hit way, set dirty=dirty_i, make the way MRU, output hit_o=1 and the post-write contents.
REQ-024 Write miss SHALL install {valid=1, dirty=dirty_i, tag_i} and data_i into the victim, make it MRU, and output hit_o=0 plus the victim's pre-overwrite tag/data (evicted line).
REQ-025 LRU SHALL be true LRU via per-set age fields of log2(WAYS) bits: accessed way -> 0; ways with age less than its old age increment by 1; others unchanged. Ages within a set SHALL always be a permutation of 0..WAYS-1.
REQ-026 Back-to-back accesses to the same set SHALL see the state written by the previous access (no stale read, no bypass hazards).
REQ-027 Accesses to a set SHALL never alter state of any other set.

Reset
REQ-028 While rst_i is high, all valid and dirty bits SHALL be 0, each set's way-w age SHALL be w, and valid_o, hit_o, tag_o, data_o, way_o SHALL be 0.
REQ-029 The data array SHALL NOT be reset (SRAM macro); reads of never-written lines are undefined but never hits.
REQ-030 Reset asserted mid-access SHALL abort it: no array write occurs and valid_o stays 0 until the first access after release.

Structure
REQ-031 Defaults for WAYS, SETS, TAG_W, LINE_W and the tag_o field offsets (VALID_BIT, DIRTY_BIT) SHALL live in shared package dcache_pkg.
REQ-032 Age update and victim selection SHALL be one sub-module, dcache_lru_age, instantiated once and operating on the addressed set's age vector.

Verification (WAYS=4, SETS=16)
REQ-033 Reset, then read set 3 tag 0x1 -> valid_o=1, hit_o=0, tag_o valid bit 0, way_o=0.
REQ-034 Write tags 0xA,0xB,0xC,0xD to set 5 with dirty_i=1 -> ways 0..3 filled in order; re-read 0xC -> hit_o=1, way_o=2, data_o matches.
REQ-035 After REQ-034 read 0xA, then write miss 0xE to set 5 -> evicts way 1 (tag 0xB); tag_o={1,1,0xB}, 0xE hit on next read.
REQ-036 Write hit 0xE with dirty_i=0 -> tag_o dirty bit 0, data_o=new line, ages unchanged except MRU update.
REQ-037 Alternating accesses to sets 0 and 15 back-to-back for 64 cycles -> scoreboard matches; other sets' state untouched.
REQ-038 Assert rst_i mid write miss -> no install; all subsequent reads miss; valid_o=0 until next access.
